pipe_ctrl_gen: RTL
==================

Name: pipe_ctrl_gen

Overview:
Parametrised successor of the core's pipeline control unit. Takes resource-full flags from the front end and back end, plus per-lane retire status from the ROB head. Produces the commit mask, flush, and front/back freeze signals. Unlike the previous purely combinational control, it sequences exception recovery through a multi-cycle FSM (flush hold, then ARAT-copy recovery window) and keeps saturating stall/flush counters.

Parameters:
RET_W, 3, retire lanes per cycle (lane 0 = oldest)
N_FULL_FE, 5, front-end full flags (PRF, RS_add, RS_mul, RS_agu, LSQ)
N_FULL_BE, 2, back-end full flags (ROB, FIFO)
FLUSH_CYC, 1, cycles flush is held high (>=1)
RECOVER_CYC, 2, cycles of ARAT-copy recovery after flush (>=1)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
full_fe  in  N_FULL_FE  front-end structure full flags
full_be  in  N_FULL_BE  back-end structure full flags
ready_ret  in  RET_W  ROB head lane i completed
excep_ret  in  RET_W  ROB head lane i raised exception (qualified by ready_ret[i])
ret_mask  out  RET_W  lanes committing this cycle (combinational)
flush  out  1  pipeline flush (registered)
freeze_front  out  1  stall fetch/rename/dispatch
freeze_back  out  1  stall ROB allocation/issue
recovering  out  1  FSM in FLUSH or RECOVER
excep_lane  out  $clog2(RET_W)  lane index of the last taken exception (registered)
cnt_stall  out  CNT_W  saturating count of cycles with freeze_front=1 in RUN
cnt_flush  out  CNT_W  saturating count of exceptions taken

Behaviour:
- Clock domain clk; rst asynchronous, active-high. On reset, all state clears immediately: FSM=RUN, flush=0, recovering=0, excep_lane=0, cnt_stall=0, cnt_flush=0, down-counter=0.
- While rst=1, the combinational outputs also read 0: ret_mask=0, freeze_front=0, freeze_back=0.
- Commit rule (RUN only):
  - Lane i is eligible if ready_ret[0..i] are all 1.
  - k = lowest eligible lane with excep_ret[k]=1.
  - ret_mask = eligible lanes below k; lane k does not commit. With no exception, ret_mask = all eligible lanes.
  - A gap stops commit: ready_ret=3'b101 gives ret_mask=3'b001.
- Exception detection is combinational in RUN. Next edge: state<=FLUSH, excep_lane<=k, cnt_flush++ (saturating at all-ones), down-counter<=FLUSH_CYC-1.
- FSM states:
  - RUN: flush=0, recovering=0. freeze_front = |full_fe or |full_be. freeze_back = |full_be.
  - FLUSH: flush=1, freeze_front=1, freeze_back=1, ret_mask=0. When the down-counter reaches 0: state<=RECOVER, counter<=RECOVER_CYC-1. Otherwise decrement.
  - RECOVER: flush=0, freeze_front=1, freeze_back=0 (back end copies ARAT to RAT/freelist), ret_mask=0. When the counter reaches 0: state<=RUN.
- recovering = (state != RUN).
- flush is driven from a state register, not from excep_ret, so it is glitch-free.
- excep_ret and ready_ret are ignored outside RUN. A new exception cannot be taken until back in RUN.
- Full flags are ignored in FLUSH/RECOVER; freezes follow the state rules above.
- cnt_stall increments (saturating) each RUN cycle with freeze_front=1, including a cycle where an exception is also detected.
- Exception and full in the same RUN cycle: ret_mask still computed per the commit rule; freeze outputs per full flags; FSM moves to FLUSH next edge.
- Reset asserted mid-FLUSH/RECOVER: immediate return to RUN, counters cleared; no residual flush pulse.
- Total exception penalty: detection cycle + FLUSH_CYC + RECOVER_CYC before commits resume.

Decomposition:
- Package pipe_ctrl_pkg: state enum {ST_RUN, ST_FLUSH, ST_RECOVER} (2-bit), counter-width helper, default parameter constants.
- Sub-module excep_prio_enc (param RET_W): computes the eligible prefix, first excepting lane k, valid bit and ret_mask; purely combinational, reusable by the ROB.
- Top holds the FSM, down-counter and perf counters.

Test Plan:
1. Reset, then ready_ret=3'b111, excep_ret=0, fulls=0 -> ret_mask=3'b111, flush=0, freeze_front=0, freeze_back=0; cnt_flush=0.
2. ready_ret=3'b111, excep_ret=3'b010 (defaults) -> ret_mask=3'b001 that cycle. Next cycle: flush=1, excep_lane=1, cnt_flush=1. Then 2 cycles of recovering with flush=0, freeze_front=1, freeze_back=0. Then RUN.
3. full_be=2'b01 for 4 cycles in RUN -> freeze_front=1, freeze_back=1 each cycle; cnt_stall=4. full_fe=5'b00100 only -> freeze_front=1, freeze_back=0.
4. Exception on lane 0 while full_fe=1; then excep_ret=3'b111 repeatedly during FLUSH/RECOVER -> ret_mask=0 in the detection cycle and throughout. Only one flush sequence; cnt_flush=1.
5. Assert rst asynchronously during the RECOVER cycle of FLUSH_CYC=2, RECOVER_CYC=3 -> outputs drop to 0 before the next edge. After release: state RUN, ret_mask follows ready_ret immediately.
6. Preload cnt_stall to 16'hFFFE via forced stall run -> after 3 more stall cycles it holds 16'hFFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and sizing helpers for the pipeline control unit and its
// exception priority encoder.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } state_e;

  localparam int unsigned DEF_RET_W       = 3;
  localparam int unsigned DEF_N_FULL_FE   = 5;
  localparam int unsigned DEF_N_FULL_BE   = 2;
  localparam int unsigned DEF_FLUSH_CYC   = 1;
  localparam int unsigned DEF_RECOVER_CYC = 2;
  localparam int unsigned DEF_CNT_W       = 16;

  // Bits needed to index n items; never below 1 so degenerate sizes still elaborate.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Down-counter width able to hold max(a, b) - 1.
  function automatic int unsigned dcnt_w(input int unsigned a, input int unsigned b);
    return idx_w((a > b) ? a : b);
  endfunction

endpackage

// File: rtl/excep_prio_enc.sv
// Retire-lane priority encoder: in-order eligible prefix, first excepting
// lane, and the resulting commit mask. Purely combinational.
module excep_prio_enc
  import pipe_ctrl_pkg::*;
#(
  parameter  int unsigned RET_W  = DEF_RET_W,
  localparam int unsigned LANE_W = idx_w(RET_W)
) (
  input  logic [RET_W-1:0]  ready_ret,
  input  logic [RET_W-1:0]  excep_ret,
  output logic [RET_W-1:0]  ret_mask,
  output logic [LANE_W-1:0] excep_lane,
  output logic              excep_valid
);

  logic [RET_W-1:0] eligible;
  logic             run;

  always_comb begin
    eligible    = '0;
    ret_mask    = '0;
    excep_lane  = '0;
    excep_valid = 1'b0;
    run         = 1'b1;
    for (int unsigned i = 0; i < RET_W; i++) begin
      run         = run & ready_ret[i];
      eligible[i] = run;
    end
    // Lanes commit up to, but not including, the oldest excepting eligible lane.
    for (int unsigned i = 0; i < RET_W; i++) begin
      if (eligible[i] && !excep_valid) begin
        if (excep_ret[i]) begin
          excep_valid = 1'b1;
          excep_lane  = LANE_W'(i);
        end else begin
          ret_mask[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Pipeline control: commit mask, freeze generation, and a RUN/FLUSH/RECOVER
// exception-recovery FSM with saturating stall and flush counters.
module pipe_ctrl_gen
  import pipe_ctrl_pkg::*;
#(
  parameter  int unsigned RET_W       = DEF_RET_W,
  parameter  int unsigned N_FULL_FE   = DEF_N_FULL_FE,
  parameter  int unsigned N_FULL_BE   = DEF_N_FULL_BE,
  parameter  int unsigned FLUSH_CYC   = DEF_FLUSH_CYC,
  parameter  int unsigned RECOVER_CYC = DEF_RECOVER_CYC,
  parameter  int unsigned CNT_W       = DEF_CNT_W,
  localparam int unsigned LANE_W      = idx_w(RET_W)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_FULL_FE-1:0] full_fe,
  input  logic [N_FULL_BE-1:0] full_be,
  input  logic [RET_W-1:0]     ready_ret,
  input  logic [RET_W-1:0]     excep_ret,
  output logic [RET_W-1:0]     ret_mask,
  output logic                 flush,
  output logic                 freeze_front,
  output logic                 freeze_back,
  output logic                 recovering,
  output logic [LANE_W-1:0]    excep_lane,
  output logic [CNT_W-1:0]     cnt_stall,
  output logic [CNT_W-1:0]     cnt_flush
);

  localparam int unsigned DC_W = dcnt_w(FLUSH_CYC, RECOVER_CYC);

  state_e            state_q, state_d;
  logic [DC_W-1:0]   dcnt_q, dcnt_d;
  logic [LANE_W-1:0] lane_d;
  logic [CNT_W-1:0]  cnt_stall_d, cnt_flush_d;
  logic [RET_W-1:0]  enc_mask;
  logic [LANE_W-1:0] enc_lane;
  logic              enc_valid;

  excep_prio_enc #(.RET_W(RET_W)) u_enc (
    .ready_ret   (ready_ret),
    .excep_ret   (excep_ret),
    .ret_mask    (enc_mask),
    .excep_lane  (enc_lane),
    .excep_valid (enc_valid)
  );

  always_comb begin
    state_d      = state_q;
    dcnt_d       = dcnt_q;
    lane_d       = excep_lane;
    cnt_stall_d  = cnt_stall;
    cnt_flush_d  = cnt_flush;
    ret_mask     = '0;
    freeze_front = 1'b0;
    freeze_back  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        ret_mask     = enc_mask;
        freeze_front = (|full_fe) | (|full_be);
        freeze_back  = |full_be;
        if (freeze_front && (cnt_stall != '1)) cnt_stall_d = cnt_stall + 1'b1;
        if (enc_valid) begin
          state_d = ST_FLUSH;
          lane_d  = enc_lane;
          dcnt_d  = DC_W'(FLUSH_CYC - 1);
          if (cnt_flush != '1) cnt_flush_d = cnt_flush + 1'b1;
        end
      end
      ST_FLUSH: begin
        freeze_front = 1'b1;
        freeze_back  = 1'b1;
        if (dcnt_q == '0) begin
          state_d = ST_RECOVER;
          dcnt_d  = DC_W'(RECOVER_CYC - 1);
        end else begin
          dcnt_d = dcnt_q - 1'b1;
        end
      end
      ST_RECOVER: begin
        freeze_front = 1'b1;
        if (dcnt_q == '0) state_d = ST_RUN;
        else              dcnt_d  = dcnt_q - 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
    // Combinational outputs must read idle while reset is held, not just after the edge.
    if (rst) begin
      ret_mask     = '0;
      freeze_front = 1'b0;
      freeze_back  = 1'b0;
    end
  end

  always_comb begin
    flush      = (state_q == ST_FLUSH);
    recovering = (state_q != ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      dcnt_q     <= '0;
      excep_lane <= '0;
      cnt_stall  <= '0;
      cnt_flush  <= '0;
    end else begin
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
      excep_lane <= lane_d;
      cnt_stall  <= cnt_stall_d;
      cnt_flush  <= cnt_flush_d;
    end
  end

endmodule
